// File: rtl/alu_operand_stage.sv
// Operand select and RAW forwarding into a one-entry valid/ready register ahead of EX.
// Latency: 1 cycle from capture to OutValid. Throughput: 1 entry per cycle.
// Backpressure: InReady drops while an entry is held and OutReady is low; blocked cycles are counted.
module alu_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32,
  parameter int NUM_FWD  = 2,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [REG_AW-1:0]         Rs1Addr,
  input  logic [REG_AW-1:0]         Rs2Addr,
  input  logic [WIDTH-1:0]          Rs1Data,
  input  logic [WIDTH-1:0]          Rs2Data,
  input  logic [PC_WIDTH-1:0]       PC,
  input  logic [WIDTH-1:0]          Immediate,
  input  logic [1:0]                ALUSrc1,
  input  logic [1:0]                ALUSrc2,
  input  logic [NUM_FWD-1:0]        FwdValid,
  input  logic [NUM_FWD*REG_AW-1:0] FwdRd,
  input  logic [NUM_FWD*WIDTH-1:0]  FwdData,
  input  logic                      Flush,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [WIDTH-1:0]          Op1,
  output logic [WIDTH-1:0]          Op2,
  output logic [WIDTH-1:0]          StoreData,
  output logic [CNT_W-1:0]          StallCnt
);

  logic [WIDTH-1:0] rs1_res;
  logic [WIDTH-1:0] rs2_res;
  logic [WIDTH-1:0] pc_ext;
  logic [WIDTH-1:0] const_four;
  logic [WIDTH-1:0] op1_nxt;
  logic [WIDTH-1:0] op2_nxt;
  logic             capture;
  logic             stall;

  assign InReady = !OutValid || OutReady;
  assign capture = InValid && InReady && !Flush;
  assign stall   = InValid && !InReady && !Flush;

  // Walk from oldest to youngest so the lowest matching index wins; x0 is never forwarded.
  always_comb begin
    rs1_res = Rs1Data;
    rs2_res = Rs2Data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (FwdValid[i] && (FwdRd[i*REG_AW +: REG_AW] == Rs1Addr))
        rs1_res = FwdData[i*WIDTH +: WIDTH];
      if (FwdValid[i] && (FwdRd[i*REG_AW +: REG_AW] == Rs2Addr))
        rs2_res = FwdData[i*WIDTH +: WIDTH];
    end
    if (Rs1Addr == '0) rs1_res = '0;
    if (Rs2Addr == '0) rs2_res = '0;
  end

  always_comb begin
    pc_ext                 = '0;
    pc_ext[PC_WIDTH-1:0]   = PC;
    const_four             = '0;
    const_four[2]          = 1'b1;
  end

  always_comb begin
    case (ALUSrc1)
      2'b00:   op1_nxt = rs1_res;
      2'b01:   op1_nxt = pc_ext;
      default: op1_nxt = '0;
    endcase
    case (ALUSrc2)
      2'b00:   op2_nxt = rs2_res;
      2'b01:   op2_nxt = Immediate;
      2'b10:   op2_nxt = const_four;
      default: op2_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OutValid  <= 1'b0;
      Op1       <= '0;
      Op2       <= '0;
      StoreData <= '0;
    end else if (Flush) begin
      OutValid  <= 1'b0;
    end else if (capture) begin
      OutValid  <= 1'b1;
      Op1       <= op1_nxt;
      Op2       <= op2_nxt;
      StoreData <= rs2_res;
    end else if (OutReady) begin
      OutValid  <= 1'b0;
    end
  end

  // Saturates instead of wrapping so long stalls remain visible.
  always_ff @(posedge clk) begin
    if (rst)
      StallCnt <= '0;
    else if (stall && (StallCnt != '1))
      StallCnt <= StallCnt + CNT_W'(1);
  end

endmodule
